// File: rtl/logs_orbit_sequencer.sv
// Logistic-map orbit sequencer: sweeps r, seeds x, burns off transients and
// streams (x, r) orbit points over valid/ready for a bifurcation plotter.

module logs_iterate_map #(
  parameter int FRAC = 4
) (
  input  logic [FRAC-1:0] x,
  input  logic [FRAC+1:0] r,
  output logic [FRAC-1:0] next_x
);
  localparam logic [FRAC:0] ONE = {1'b1, {FRAC{1'b0}}};

  logic [FRAC:0]     one_m_x;
  logic [2*FRAC:0]   xx;
  logic [FRAC-1:0]   p;
  logic [2*FRAC+1:0] rp;

  // x*(1-x) <= 0.25 and r < 4, so both truncated products stay inside [0,1)
  assign one_m_x = ONE - {1'b0, x};
  assign xx      = {{(FRAC+1){1'b0}}, x} * {{FRAC{1'b0}}, one_m_x};
  assign p       = xx[2*FRAC-1:FRAC];
  assign rp      = {{FRAC{1'b0}}, r} * {{(FRAC+2){1'b0}}, p};
  assign next_x  = rp[2*FRAC-1:FRAC];
endmodule

module logs_orbit_sequencer #(
  parameter int FRAC    = 4,
  parameter int BURN_IN = 16,
  parameter int SAMPLES = 8,
  parameter logic [FRAC-1:0] X0 = FRAC'(2**(FRAC-1))
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            start,
  input  logic [FRAC+1:0] r_start,
  input  logic [FRAC+1:0] r_step,
  input  logic [7:0]      r_steps,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FRAC-1:0] out_x,
  output logic [FRAC+1:0] out_r,
  output logic            busy,
  output logic            done
);
  localparam logic [7:0] BURN_N = 8'(BURN_IN);
  localparam logic [7:0] SAMP_N = 8'(SAMPLES);

  typedef enum logic [2:0] {IDLE, SEED, BURN, EMIT, NEXT_R} state_t;

  state_t          state;
  logic [FRAC-1:0] x_reg, next_x;
  logic [FRAC+1:0] r_reg;
  logic [7:0]      burn_cnt, samp_cnt, r_left;
  logic            done_q;

  logs_iterate_map #(.FRAC(FRAC)) u_map (
    .x      (x_reg),
    .r      (r_reg),
    .next_x (next_x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_reg    <= X0;
      r_reg    <= '0;
      burn_cnt <= '0;
      samp_cnt <= '0;
      r_left   <= '0;
      done_q   <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          r_reg  <= r_start;
          r_left <= r_steps;
          if (r_steps == 8'd0) done_q <= 1'b1;
          else                 state  <= SEED;
        end
        SEED: begin
          x_reg    <= X0;
          burn_cnt <= BURN_N;
          if (BURN_N == 8'd0) begin
            state    <= EMIT;
            samp_cnt <= SAMP_N;
          end else begin
            state <= BURN;
          end
        end
        BURN: begin
          x_reg    <= next_x;
          burn_cnt <= burn_cnt - 8'd1;
          if (burn_cnt == 8'd1) begin
            state    <= EMIT;
            samp_cnt <= SAMP_N;
          end
        end
        EMIT: if (out_ready) begin
          // each accepted point advances the orbit by exactly one iteration
          x_reg    <= next_x;
          samp_cnt <= samp_cnt - 8'd1;
          if (samp_cnt == 8'd1) state <= NEXT_R;
        end
        NEXT_R: begin
          r_left <= r_left - 8'd1;
          if (r_left == 8'd1) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            r_reg <= r_reg + r_step;
            state <= SEED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == EMIT) & ena;
  assign done      = done_q & ena;
  assign busy      = (state != IDLE);
  assign out_x     = x_reg;
  assign out_r     = r_reg;
endmodule

// File: tb/tb_logs_orbit_sequencer.sv
// Directed bench: dut_a uses default BURN_IN/SAMPLES, dut_b uses BURN_IN=0,
// SAMPLES=3; both share every input and are checked against hand-computed orbits.

module tb_logs_orbit_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, ena, start, out_ready;
  logic [5:0] r_start, r_step;
  logic [7:0] r_steps;

  logic       a_valid, a_busy, a_done, b_valid, b_busy, b_done;
  logic [3:0] a_x, b_x;
  logic [5:0] a_r, b_r;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logs_orbit_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .r_start(r_start), .r_step(r_step), .r_steps(r_steps),
    .out_valid(a_valid), .out_ready(out_ready), .out_x(a_x), .out_r(a_r),
    .busy(a_busy), .done(a_done)
  );

  logs_orbit_sequencer #(.BURN_IN(0), .SAMPLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .r_start(r_start), .r_step(r_step), .r_steps(r_steps),
    .out_valid(b_valid), .out_ready(out_ready), .out_x(b_x), .out_r(b_r),
    .busy(b_busy), .done(b_done)
  );

  // transfer / done monitor
  logic [3:0] qa_x[$], qb_x[$];
  logic [5:0] qa_r[$], qb_r[$];
  int done_a = 0, done_b = 0;

  always @(posedge clk) begin
    if (a_valid && out_ready) begin qa_x.push_back(a_x); qa_r.push_back(a_r); end
    if (b_valid && out_ready) begin qb_x.push_back(b_x); qb_r.push_back(b_r); end
    if (a_done) done_a++;
    if (b_done) done_b++;
  end

  typedef struct {
    logic [5:0]      r;
    logic [2:0][3:0] xs;   // xs[0] is the first emitted point
  } vec_t;

  vec_t tbl[6];
  int   wrap_r[9] = '{60, 60, 60, 4, 4, 4, 12, 12, 12};
  int   wrap_x[9] = '{8, 15, 0, 8, 1, 0, 8, 3, 1};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    qa_x.delete(); qa_r.delete(); qb_x.delete(); qb_r.delete();
    done_a = 0; done_b = 0;
  endtask

  // returns at the negedge one cycle after start was sampled (k=1)
  task automatic start_sweep(input logic [5:0] rs, input logic [5:0] st, input logic [7:0] n);
    @(negedge clk);
    clear_mon();
    r_start = rs; r_step = st; r_steps = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((a_busy || b_busy) && n < 400) begin @(negedge clk); n++; end
    chk({name, "_idle"}, 32'(n < 400), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int first_v, last_b, done_k, bad, n;
    logic seen;

    tbl[0].r = 6'd48; tbl[0].xs = {4'd9, 4'd12, 4'd8};
    tbl[1].r = 6'd32; tbl[1].xs = {4'd8, 4'd8,  4'd8};
    tbl[2].r = 6'd63; tbl[2].xs = {4'd0, 4'd15, 4'd8};
    tbl[3].r = 6'd0;  tbl[3].xs = {4'd0, 4'd0,  4'd8};
    tbl[4].r = 6'd40; tbl[4].xs = {4'd7, 4'd10, 4'd8};
    tbl[5].r = 6'd56; tbl[5].xs = {4'd3, 4'd14, 4'd8};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; out_ready = 1'b1;
    r_start = '0; r_step = '0; r_steps = '0;
    #12;
    chk("reset_a", {a_valid, a_busy, a_done, 2'b0, a_x, a_r}, {5'b0, 4'd8, 6'd0});
    chk("reset_b", {b_valid, b_busy, b_done, 2'b0, b_x, b_r}, {5'b0, 4'd8, 6'd0});
    @(negedge clk) rst_n = 1'b1;

    // single-r orbits with no burn-in
    for (int t = 0; t < 6; t++) begin
      start_sweep(tbl[t].r, 6'd0, 8'd1);
      wait_idle($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_count", t), qb_x.size(), 3);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tbl%0d_x%0d", t, i), (i < qb_x.size()) ? 32'(qb_x[i]) : 32'hffff, 32'(tbl[t].xs[i]));
        chk($sformatf("tbl%0d_r%0d", t, i), (i < qb_r.size()) ? 32'(qb_r[i]) : 32'hffff, 32'(tbl[t].r));
      end
      chk($sformatf("tbl%0d_done", t), done_b, 1);
    end

    // sweep that wraps r past 2**6
    start_sweep(6'd60, 6'd8, 8'd3);
    wait_idle("wrap");
    chk("wrap_b_count", qb_x.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("wrap_b_r%0d", i), (i < qb_r.size()) ? 32'(qb_r[i]) : 32'hffff, wrap_r[i]);
      chk($sformatf("wrap_b_x%0d", i), (i < qb_x.size()) ? 32'(qb_x[i]) : 32'hffff, wrap_x[i]);
    end
    chk("wrap_b_done", done_b, 1);
    chk("wrap_a_count", qa_r.size(), 24);
    bad = 0;
    for (int i = 0; i < qa_r.size(); i++)
      if (qa_r[i] != ((i < 8) ? 6'd60 : (i < 16) ? 6'd4 : 6'd12)) bad++;
    chk("wrap_a_r_bad", bad, 0);
    chk("wrap_a_done", done_a, 1);

    // timing, default parameters, two r values; span counts the start cycle
    first_v = -1; last_b = -1; done_k = -1;
    start_sweep(6'd48, 6'd8, 8'd2);
    for (int k = 1; k <= 70; k++) begin
      if (a_valid && first_v < 0) first_v = k;
      if (a_busy) last_b = k;
      if (a_done && done_k < 0) done_k = k;
      @(negedge clk);
    end
    chk("timing_first_valid", first_v, 18);
    chk("timing_busy_span", last_b + 1, 1 + 2 * 26);
    chk("timing_done_k", done_k, 53);
    chk("timing_done_cnt", done_a, 1);

    // backpressure inside EMIT on dut_b
    start_sweep(6'd56, 6'd0, 8'd1);
    n = 0;
    while (!b_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_reach_emit", 32'(b_valid), 1);
    @(negedge clk);
    out_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if ({b_valid, b_x, b_r} != {1'b1, 4'd14, 6'd56}) bad++;
      @(negedge clk);
    end
    chk("bp_hold_bad", bad, 0);
    out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_count", qb_x.size(), 3);
    chk("bp_x1", (qb_x.size() > 1) ? 32'(qb_x[1]) : 32'hffff, 14);
    chk("bp_x2", (qb_x.size() > 2) ? 32'(qb_x[2]) : 32'hffff, 3);
    chk("bp_a_count", qa_x.size(), 8);

    // asynchronous reset while dut_a is emitting
    start_sweep(6'd48, 6'd0, 8'd1);
    n = 0;
    while (!a_valid && n < 40) begin @(negedge clk); n++; end
    chk("rst_reach_emit", 32'(a_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_emit", {a_valid, a_busy, a_done, 2'b0, a_x, a_r}, {5'b0, 4'd8, 6'd0});
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) clear_mon();

    // r_steps == 0
    start_sweep(6'd48, 6'd8, 8'd0);
    chk("zero_done_k1", {a_done, b_done}, 2'b11);
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      seen |= a_busy | b_busy;
      @(negedge clk);
    end
    chk("zero_busy_never", 32'(seen), 0);
    chk("zero_done_cnt", done_a, 1);

    // start while busy is ignored
    start_sweep(6'd48, 6'd0, 8'd1);
    repeat (8) @(negedge clk);
    r_start = 6'd20; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle("busy_start");
    chk("busy_start_count", qa_r.size(), 8);
    bad = 0;
    foreach (qa_r[i]) if (qa_r[i] != 6'd48) bad++;
    chk("busy_start_r_bad", bad, 0);
    chk("busy_start_done", done_a, 1);
    seen = 1'b0;
    repeat (3) begin seen |= a_busy; @(negedge clk); end
    chk("busy_start_no_restart", 32'(seen), 0);

    // ena low for 4 cycles during burn-in
    first_v = -1; done_k = -1; bad = 0;
    start_sweep(6'd52, 6'd0, 8'd1);
    for (int k = 1; k <= 45; k++) begin
      if (k == 3) begin chk("ena_pre_x", a_x, 13); ena = 1'b0; end
      if (k >= 4 && k <= 7 && {a_busy, a_valid, a_x} != {1'b1, 1'b0, 4'd13}) bad++;
      if (k == 7) ena = 1'b1;
      if (a_valid && first_v < 0) first_v = k;
      if (a_done && done_k < 0) done_k = k;
      @(negedge clk);
    end
    chk("ena_frozen_bad", bad, 0);
    chk("ena_first_valid", first_v, 22);
    chk("ena_done_k", done_k, 31);
    chk("ena_a_count", qa_x.size(), 8);
    bad = 0;
    foreach (qa_x[i]) if (qa_x[i] != 4'd9) bad++;
    chk("ena_a_x_bad", bad, 0);
    chk("ena_b_count", qb_x.size(), 3);
    chk("ena_b_x1", (qb_x.size() > 1) ? 32'(qb_x[1]) : 32'hffff, 13);
    chk("ena_b_x2", (qb_x.size() > 2) ? 32'(qb_x[2]) : 32'hffff, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
